// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// Each access is sequenced by a small FSM; completion is a one-cycle valid pulse.
module imem_dmem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                resetn,
  // Instruction fetch side
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic                inst_cancel,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_valid,
  // Load/store side
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_valid,
  // Hazard unit
  output logic                stall_if,
  output logic                stall_mem,
  // Memory side
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_timeout
);

  localparam int unsigned StrbW = DATA_W / 8;
  localparam int unsigned CntW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    StIdle,
    StInstBusy,
    StDataBusy,
    StDrain
  } state_e;

  state_e              state_q, state_d;
  logic                last_data_q, last_data_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_wr_q, mem_wr_d;
  logic [StrbW-1:0]    mem_wstrb_q, mem_wstrb_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
  logic                inst_valid_q, inst_valid_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
  logic                data_valid_q, data_valid_d;
  logic                mem_timeout_q, mem_timeout_d;

  logic inst_pend;
  logic data_pend;
  logic timed_out;

  // A requester still holds its request during its own valid cycle; mask it so
  // the finished access is not granted a second time.
  assign inst_pend = inst_req & ~inst_valid_q & ~inst_cancel;
  assign data_pend = data_req & ~data_valid_q;
  assign timed_out = (cnt_q == CntW'(TIMEOUT - 1)) & ~mem_ack;

  always_comb begin
    state_d       = state_q;
    last_data_d   = last_data_q;
    mem_req_d     = mem_req_q;
    mem_wr_d      = mem_wr_q;
    mem_wstrb_d   = mem_wstrb_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    cnt_d         = cnt_q;
    inst_rdata_d  = inst_rdata_q;
    inst_valid_d  = 1'b0;
    data_rdata_d  = data_rdata_q;
    data_valid_d  = 1'b0;
    mem_timeout_d = mem_timeout_q;

    unique case (state_q)
      StIdle: begin
        // On a tie the side that did not win last time is served.
        if (data_pend && (!inst_pend || !last_data_q)) begin
          state_d     = StDataBusy;
          last_data_d = 1'b1;
          mem_req_d   = 1'b1;
          mem_wr_d    = data_wr;
          mem_wstrb_d = data_wr ? data_wstrb : '0;
          mem_addr_d  = data_addr;
          mem_wdata_d = data_wdata;
          cnt_d       = '0;
        end else if (inst_pend) begin
          state_d     = StInstBusy;
          last_data_d = 1'b0;
          mem_req_d   = 1'b1;
          mem_wr_d    = 1'b0;
          mem_wstrb_d = '0;
          mem_addr_d  = inst_addr;
          mem_wdata_d = '0;
          cnt_d       = '0;
        end
      end

      StInstBusy: begin
        if (mem_ack) begin
          // A flush arriving with the ack still discards the word.
          state_d      = StIdle;
          mem_req_d    = 1'b0;
          inst_valid_d = ~inst_cancel;
          if (!inst_cancel) begin
            inst_rdata_d = mem_rdata;
          end
        end else if (timed_out) begin
          state_d       = StIdle;
          mem_req_d     = 1'b0;
          mem_timeout_d = 1'b1;
          inst_valid_d  = ~inst_cancel;
          inst_rdata_d  = '0;
          cnt_d         = cnt_q + CntW'(1);
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (inst_cancel) begin
            state_d = StDrain;
          end
        end
      end

      StDataBusy: begin
        if (mem_ack) begin
          state_d      = StIdle;
          mem_req_d    = 1'b0;
          data_valid_d = 1'b1;
          if (!mem_wr_q) begin
            data_rdata_d = mem_rdata;
          end
        end else if (timed_out) begin
          state_d       = StIdle;
          mem_req_d     = 1'b0;
          mem_timeout_d = 1'b1;
          data_valid_d  = 1'b1;
          data_rdata_d  = '0;
          cnt_d         = cnt_q + CntW'(1);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StDrain: begin
        if (mem_ack) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
        end else if (timed_out) begin
          state_d       = StIdle;
          mem_req_d     = 1'b0;
          mem_timeout_d = 1'b1;
          cnt_d         = cnt_q + CntW'(1);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StIdle;
      last_data_q   <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_wstrb_q   <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      cnt_q         <= '0;
      inst_rdata_q  <= '0;
      inst_valid_q  <= 1'b0;
      data_rdata_q  <= '0;
      data_valid_q  <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_data_q   <= last_data_d;
      mem_req_q     <= mem_req_d;
      mem_wr_q      <= mem_wr_d;
      mem_wstrb_q   <= mem_wstrb_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      cnt_q         <= cnt_d;
      inst_rdata_q  <= inst_rdata_d;
      inst_valid_q  <= inst_valid_d;
      data_rdata_q  <= data_rdata_d;
      data_valid_q  <= data_valid_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign inst_rdata  = inst_rdata_q;
  assign inst_valid  = inst_valid_q;
  assign data_rdata  = data_rdata_q;
  assign data_valid  = data_valid_q;
  assign mem_req     = mem_req_q;
  assign mem_wr      = mem_wr_q;
  assign mem_wstrb   = mem_wstrb_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_timeout = mem_timeout_q;
  assign stall_if    = inst_req & ~inst_valid_q;
  assign stall_mem   = data_req & ~data_valid_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter; a second instance with TIMEOUT=4
// shares the stimulus and is checked only in the timeout scenario.
module tb_imem_dmem_arbiter;

  logic        clk;
  logic        resetn;
  logic        inst_req, inst_cancel, data_req, data_wr, mem_ack;
  logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
  logic [3:0]  data_wstrb;

  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic        inst_valid, data_valid, stall_if, stall_mem, mem_req, mem_wr, mem_timeout;
  logic [3:0]  mem_wstrb;

  logic [31:0] t_inst_rdata, t_data_rdata, t_mem_addr, t_mem_wdata;
  logic        t_inst_valid, t_data_valid, t_stall_if, t_stall_mem, t_mem_req, t_mem_wr;
  logic        t_mem_timeout;
  logic [3:0]  t_mem_wstrb;

  int n_vec = 0;
  int n_err = 0;

  imem_dmem_arbiter u_dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_rdata(inst_rdata), .inst_valid(inst_valid),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_valid(data_valid),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_timeout(mem_timeout)
  );

  imem_dmem_arbiter #(.TIMEOUT(4)) u_dut_to (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_rdata(t_inst_rdata), .inst_valid(t_inst_valid),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(t_data_rdata), .data_valid(t_data_valid),
    .stall_if(t_stall_if), .stall_mem(t_stall_mem),
    .mem_req(t_mem_req), .mem_wr(t_mem_wr), .mem_wstrb(t_mem_wstrb), .mem_addr(t_mem_addr),
    .mem_wdata(t_mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_timeout(t_mem_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_inputs();
    inst_req = 0; inst_cancel = 0; data_req = 0; data_wr = 0; mem_ack = 0;
    inst_addr = 0; data_addr = 0; data_wdata = 0; mem_rdata = 0; data_wstrb = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 0;
    clear_inputs();
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if ({mem_req, mem_wr, mem_wstrb, inst_valid, data_valid, mem_timeout, stall_if, stall_mem}
        !== 10'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0", {mem_req, mem_wr, mem_wstrb,
                        inst_valid, data_valid, mem_timeout, stall_if, stall_mem});
    end
    n_vec++;
    if ({inst_rdata, data_rdata, mem_addr, mem_wdata} !== 128'b0) begin
      n_err++; $display("FAIL reset_data: got %h want 0",
                        {inst_rdata, data_rdata, mem_addr, mem_wdata});
    end
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic test_single_fetch();
    @(negedge clk); inst_req = 1; inst_addr = 32'h0000_0040; #1;
    n_vec++;
    if ({stall_if, mem_req} !== 2'b10) begin
      n_err++; $display("FAIL fetch_c0: got %b want 10", {stall_if, mem_req});
    end
    @(negedge clk); mem_ack = 1; mem_rdata = 32'h2408_0005; #1;
    n_vec++;
    if ({stall_if, mem_req, mem_wr, mem_wstrb, mem_addr} !== {3'b110, 4'b0, 32'h40}) begin
      n_err++; $display("FAIL fetch_c1: got %h want %h",
                        {stall_if, mem_req, mem_wr, mem_wstrb, mem_addr}, {3'b110, 4'b0, 32'h40});
    end
    @(negedge clk); mem_ack = 0; mem_rdata = 0; #1;
    n_vec++;
    if ({inst_valid, stall_if, mem_req, inst_rdata} !== {3'b100, 32'h2408_0005}) begin
      n_err++; $display("FAIL fetch_c2: got %h want %h",
                        {inst_valid, stall_if, mem_req, inst_rdata}, {3'b100, 32'h2408_0005});
    end
    @(negedge clk); inst_req = 0; #1;
    n_vec++;
    if ({inst_valid, stall_if, mem_req} !== 3'b000) begin
      n_err++; $display("FAIL fetch_c3: got %b want 000", {inst_valid, stall_if, mem_req});
    end
  endtask

  task automatic test_tie();
    do_reset();
    @(negedge clk);
    inst_req = 1; inst_addr = 32'h40; data_req = 1; data_wr = 0; data_addr = 32'h100; #1;
    n_vec++;
    if ({stall_if, stall_mem} !== 2'b11) begin
      n_err++; $display("FAIL tie_stalls: got %b want 11", {stall_if, stall_mem});
    end
    @(negedge clk); mem_ack = 1; mem_rdata = 32'h1111_2222; #1;
    n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h100}) begin
      n_err++; $display("FAIL tie_first_data: got %h want %h", {mem_req, mem_addr}, {1'b1, 32'h100});
    end
    @(negedge clk); mem_ack = 0; #1;
    n_vec++;
    if ({data_valid, stall_mem, stall_if, data_rdata} !== {3'b101, 32'h1111_2222}) begin
      n_err++; $display("FAIL tie_data_done: got %h want %h",
                        {data_valid, stall_mem, stall_if, data_rdata}, {3'b101, 32'h1111_2222});
    end
    @(negedge clk); data_req = 0; mem_ack = 1; mem_rdata = 32'h3333_4444; #1;
    n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h40}) begin
      n_err++; $display("FAIL tie_then_inst: got %h want %h", {mem_req, mem_addr}, {1'b1, 32'h40});
    end
    @(negedge clk); mem_ack = 0; #1;
    n_vec++;
    if ({inst_valid, inst_rdata} !== {1'b1, 32'h3333_4444}) begin
      n_err++; $display("FAIL tie_inst_done: got %h want %h",
                        {inst_valid, inst_rdata}, {1'b1, 32'h3333_4444});
    end
    // Data-only access leaves last_grant = DATA.
    @(negedge clk); inst_req = 0; data_req = 1; data_addr = 32'h104; #1;
    @(negedge clk); mem_ack = 1; mem_rdata = 32'h0; #1;
    n_vec++;
    if (mem_addr !== 32'h104) begin
      n_err++; $display("FAIL solo_data_addr: got %h want %h", mem_addr, 32'h104);
    end
    @(negedge clk); mem_ack = 0; #1;
    @(negedge clk); data_addr = 32'h108; inst_req = 1; inst_addr = 32'h44; #1;
    @(negedge clk); mem_ack = 1; mem_rdata = 32'h9999_AAAA; #1;
    n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h44}) begin
      n_err++; $display("FAIL tie2_inst_first: got %h want %h", {mem_req, mem_addr}, {1'b1, 32'h44});
    end
    @(negedge clk); mem_ack = 0; #1;
    n_vec++;
    if ({inst_valid, inst_rdata} !== {1'b1, 32'h9999_AAAA}) begin
      n_err++; $display("FAIL tie2_inst_done: got %h want %h",
                        {inst_valid, inst_rdata}, {1'b1, 32'h9999_AAAA});
    end
    @(negedge clk); inst_req = 0; mem_ack = 1; mem_rdata = 32'h5555_6666; #1;
    n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h108}) begin
      n_err++; $display("FAIL tie2_then_data: got %h want %h", {mem_req, mem_addr}, {1'b1, 32'h108});
    end
    @(negedge clk); mem_ack = 0; #1;
    n_vec++;
    if ({data_valid, data_rdata} !== {1'b1, 32'h5555_6666}) begin
      n_err++; $display("FAIL tie2_data_done: got %h want %h",
                        {data_valid, data_rdata}, {1'b1, 32'h5555_6666});
    end
    @(negedge clk); data_req = 0; #1;
  endtask

  task automatic test_store();
    @(negedge clk);
    data_req = 1; data_wr = 1; data_wstrb = 4'b0011; data_wdata = 32'hDEAD_BEEF;
    data_addr = 32'h200; #1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk); #1;
      n_vec++;
      if ({mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, data_valid, stall_mem} !==
          {2'b11, 4'b0011, 32'h200, 32'hDEAD_BEEF, 2'b01}) begin
        n_err++; $display("FAIL store_busy_c%0d: got %h want %h", c,
                          {mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, data_valid, stall_mem},
                          {2'b11, 4'b0011, 32'h200, 32'hDEAD_BEEF, 2'b01});
      end
    end
    @(negedge clk); mem_ack = 1; mem_rdata = 32'hFFFF_FFFF; #1;
    @(negedge clk); mem_ack = 0; #1;
    n_vec++;
    if ({data_valid, mem_req, data_rdata} !== {2'b10, 32'h5555_6666}) begin
      n_err++; $display("FAIL store_done: got %h want %h",
                        {data_valid, mem_req, data_rdata}, {2'b10, 32'h5555_6666});
    end
    @(negedge clk); data_req = 0; data_wr = 0; data_wstrb = 0; #1;
    n_vec++;
    if (data_valid !== 1'b0) begin
      n_err++; $display("FAIL store_pulse_len: got %b want 0", data_valid);
    end
  endtask

  task automatic test_cancel();
    @(negedge clk); inst_req = 1; inst_addr = 32'h80; #1;
    @(negedge clk); inst_cancel = 1; data_req = 1; data_addr = 32'h300; #1;
    n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h80}) begin
      n_err++; $display("FAIL cancel_grant: got %h want %h", {mem_req, mem_addr}, {1'b1, 32'h80});
    end
    @(negedge clk); inst_cancel = 0; inst_req = 0; #1;
    n_vec++;
    if ({mem_req, stall_mem} !== 2'b11) begin
      n_err++; $display("FAIL cancel_drain: got %b want 11", {mem_req, stall_mem});
    end
    @(negedge clk); #1;
    @(negedge clk); #1;
    @(negedge clk); mem_ack = 1; mem_rdata = 32'hBAD0_BAD0; #1;
    @(negedge clk); mem_ack = 0; #1;
    n_vec++;
    if ({inst_valid, mem_req, inst_rdata} !== {2'b00, 32'h9999_AAAA}) begin
      n_err++; $display("FAIL cancel_discard: got %h want %h",
                        {inst_valid, mem_req, inst_rdata}, {2'b00, 32'h9999_AAAA});
    end
    @(negedge clk); mem_ack = 1; mem_rdata = 32'h7777_8888; #1;
    n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h300}) begin
      n_err++; $display("FAIL cancel_next_data: got %h want %h", {mem_req, mem_addr}, {1'b1, 32'h300});
    end
    @(negedge clk); mem_ack = 0; #1;
    n_vec++;
    if ({data_valid, inst_valid, data_rdata} !== {2'b10, 32'h7777_8888}) begin
      n_err++; $display("FAIL cancel_data_done: got %h want %h",
                        {data_valid, inst_valid, data_rdata}, {2'b10, 32'h7777_8888});
    end
    @(negedge clk); data_req = 0; #1;
  endtask

  task automatic test_timeout();
    do_reset();
    @(negedge clk); data_req = 1; data_wr = 0; data_addr = 32'h3F0; #1;
    @(negedge clk); mem_ack = 1; mem_rdata = 32'hCAFE_F00D; #1;
    @(negedge clk); mem_ack = 0; #1;
    n_vec++;
    if ({t_data_valid, t_data_rdata} !== {1'b1, 32'hCAFE_F00D}) begin
      n_err++; $display("FAIL to_preload: got %h want %h",
                        {t_data_valid, t_data_rdata}, {1'b1, 32'hCAFE_F00D});
    end
    @(negedge clk); data_addr = 32'h400; #1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      n_vec++;
      if ({t_mem_req, t_mem_timeout, t_data_valid} !== 3'b100) begin
        n_err++; $display("FAIL to_busy_%0d: got %b want 100", c,
                          {t_mem_req, t_mem_timeout, t_data_valid});
      end
    end
    @(negedge clk); #1;
    n_vec++;
    if ({t_mem_req, t_data_valid, t_mem_timeout, t_data_rdata} !== {3'b011, 32'h0}) begin
      n_err++; $display("FAIL to_expire: got %h want %h",
                        {t_mem_req, t_data_valid, t_mem_timeout, t_data_rdata}, {3'b011, 32'h0});
    end
    n_vec++;
    if ({mem_req, mem_timeout} !== 2'b10) begin
      n_err++; $display("FAIL to_long_limit: got %b want 10", {mem_req, mem_timeout});
    end
    @(negedge clk); data_req = 0; #1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    n_vec++;
    if ({t_mem_timeout, t_data_valid, t_mem_req} !== 3'b100) begin
      n_err++; $display("FAIL to_sticky: got %b want 100", {t_mem_timeout, t_data_valid, t_mem_req});
    end
    @(negedge clk); resetn = 0; #1;
    n_vec++;
    if ({t_mem_timeout, mem_req} !== 2'b00) begin
      n_err++; $display("FAIL to_reset_clear: got %b want 00", {t_mem_timeout, mem_req});
    end
    @(negedge clk); resetn = 1;
  endtask

  task automatic test_async_reset();
    @(negedge clk); data_req = 1; data_wr = 0; data_addr = 32'h500; #1;
    @(negedge clk); #1;
    n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h500}) begin
      n_err++; $display("FAIL ar_busy: got %h want %h", {mem_req, mem_addr}, {1'b1, 32'h500});
    end
    #2; resetn = 0; data_req = 0; #1;
    n_vec++;
    if ({mem_req, mem_wr, mem_addr, data_valid, data_rdata, stall_mem} !== 68'b0) begin
      n_err++; $display("FAIL ar_async_clear: got %h want 0",
                        {mem_req, mem_wr, mem_addr, data_valid, data_rdata, stall_mem});
    end
    @(negedge clk); resetn = 1;
    @(negedge clk); data_req = 1; data_addr = 32'h600; #1;
    @(negedge clk); mem_ack = 1; mem_rdata = 32'h600D_600D; #1;
    n_vec++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h600}) begin
      n_err++; $display("FAIL ar_next_grant: got %h want %h", {mem_req, mem_addr}, {1'b1, 32'h600});
    end
    @(negedge clk); mem_ack = 0; #1;
    n_vec++;
    if ({data_valid, data_rdata} !== {1'b1, 32'h600D_600D}) begin
      n_err++; $display("FAIL ar_next_done: got %h want %h",
                        {data_valid, data_rdata}, {1'b1, 32'h600D_600D});
    end
    @(negedge clk); data_req = 0; #1;
  endtask

  initial begin
    resetn = 0;
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_tie();
    test_store();
    test_cancel();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
